// File: rtl/pong_pkg.sv
// Shared pong constants: VGA 640x480@60 timing, tile geometry and coordinate widths.
// Used by the scan generator and by the game logic that consumes its tile coordinates.
package pong_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int GAME_TILE_SHIFT = 4;
  localparam int GAME_WIDTH      = VGA_H_ACTIVE >> GAME_TILE_SHIFT;
  localparam int GAME_HEIGHT     = VGA_V_ACTIVE >> GAME_TILE_SHIFT;

  localparam int COORD_W = 6;
  localparam int CNT_W   = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  function automatic coord_t tileOf(input cnt_t pix, input int shift);
    return coord_t'(pix >> shift);
  endfunction

endpackage

// File: rtl/vga_tile_scan_if.sv
// Scan outputs handed to the game: tile coordinates, frame strobes and delayed syncs.
// The scan generator drives the master side, the game reads through the slave side.
interface vga_tile_scan_if;
  import pong_pkg::*;

  coord_t o_row;
  coord_t o_col;
  logic   o_active;
  logic   o_frame_start;
  logic   o_frame_tick;
  logic   o_hsync_d;
  logic   o_vsync_d;
  logic   o_active_d;

  modport master (
    output o_row, o_col, o_active, o_frame_start, o_frame_tick,
           o_hsync_d, o_vsync_d, o_active_d
  );

  modport slave (
    input o_row, o_col, o_active, o_frame_start, o_frame_tick,
          o_hsync_d, o_vsync_d, o_active_d
  );
endinterface

// File: rtl/vga_tile_scan_sync_delay.sv
// N-deep, W-wide shift register whose stages reset to RST_VAL.
// N = 0 degenerates to a straight wire so callers need no special case.
module sync_delay #(
  parameter int             N       = 1,
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  generate
    if (N == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = i_clk ^ i_rst_n;
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [W-1:0] r_stage [N];

      // Every stage resets to the inactive pattern so no stale data survives a reset.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < N; i++) r_stage[i] <= RST_VAL;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[N-1];
    end
  endgenerate

endmodule

// File: rtl/vga_tile_scan.sv
// VGA raster scan producing tile coordinates, frame strobes and syncs delayed
// to line up with the game's registered draw output.
module vga_tile_scan
  import pong_pkg::*;
#(
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_FP         = VGA_H_FP,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BP         = VGA_H_BP,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_FP         = VGA_V_FP,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BP         = VGA_V_BP,
  parameter int TILE_SHIFT   = GAME_TILE_SHIFT,
  parameter int DRAW_LATENCY = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  vga_tile_scan_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if ((H_ACTIVE >> TILE_SHIFT) > 64) begin : g_err_cols
      $error("vga_tile_scan: H_ACTIVE >> TILE_SHIFT exceeds 64 tile columns");
    end
    if ((V_ACTIVE >> TILE_SHIFT) > 64) begin : g_err_rows
      $error("vga_tile_scan: V_ACTIVE >> TILE_SHIFT exceeds 64 tile rows");
    end
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_err_totals
      $error("vga_tile_scan: H_TOTAL/V_TOTAL do not fit a 10-bit counter");
    end
    if ((DRAW_LATENCY < 0) || (DRAW_LATENCY > 4)) begin : g_err_latency
      $error("vga_tile_scan: DRAW_LATENCY must be 0..4");
    end
  endgenerate

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t   r_hCnt, r_vCnt;
  coord_t w_row, w_col;
  logic   w_active, w_hsync, w_vsync, w_frameStart, w_frameTick;
  coord_t r_row, r_col;
  logic   r_active, r_hsync, r_vsync, r_frameStart, r_frameTick;
  logic [2:0] w_delayed;

  // Decode of the current counter position; registered below so outputs lag one edge.
  always_comb begin
    w_active     = (r_hCnt < H_ACT) && (r_vCnt < V_ACT);
    w_col        = w_active ? tileOf(r_hCnt, TILE_SHIFT) : '0;
    w_row        = w_active ? tileOf(r_vCnt, TILE_SHIFT) : '0;
    w_hsync      = !((r_hCnt >= HS_BEG) && (r_hCnt < HS_END));
    w_vsync      = !((r_vCnt >= VS_BEG) && (r_vCnt < VS_END));
    w_frameStart = (r_hCnt == '0) && (r_vCnt == '0);
    w_frameTick  = (r_hCnt == '0) && (r_vCnt == V_ACT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (r_hCnt == H_LAST) begin
      r_hCnt <= '0;
      r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + 1'b1;
    end else begin
      r_hCnt <= r_hCnt + 1'b1;
    end
  end

  // Syncs reset high (inactive) so the monitor sees no spurious pulse during reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row        <= '0;
      r_col        <= '0;
      r_active     <= 1'b0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_frameStart <= 1'b0;
      r_frameTick  <= 1'b0;
    end else begin
      r_row        <= w_row;
      r_col        <= w_col;
      r_active     <= w_active;
      r_hsync      <= w_hsync;
      r_vsync      <= w_vsync;
      r_frameStart <= w_frameStart;
      r_frameTick  <= w_frameTick;
    end
  end

  sync_delay #(
    .N       (DRAW_LATENCY),
    .W       (3),
    .RST_VAL (3'b110)
  ) u_sync_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     ({r_hsync, r_vsync, r_active}),
    .o_q     (w_delayed)
  );

  assign vga.o_row         = r_row;
  assign vga.o_col         = r_col;
  assign vga.o_active      = r_active;
  assign vga.o_frame_start = r_frameStart;
  assign vga.o_frame_tick  = r_frameTick;
  assign vga.o_hsync_d     = w_delayed[2];
  assign vga.o_vsync_d     = w_delayed[1];
  assign vga.o_active_d    = w_delayed[0];

endmodule

// File: tb/tb_vga_tile_scan.sv
// Directed bench for vga_tile_scan: default timing at latencies 0/1/2 plus a
// shrunken-timing instance so full-frame behaviour fits in a short run.
module tb_vga_tile_scan;
  import pong_pkg::*;

  logic   clk       = 1'b0;
  logic   rstN      = 1'b0;
  logic   rstSmallN = 1'b0;
  int     total     = 0;
  int     bad       = 0;
  longint curPix    = -1;
  longint smallBase = 0;

  always #20 clk = ~clk;

  vga_tile_scan_if ifL0 ();
  vga_tile_scan_if ifL1 ();
  vga_tile_scan_if ifL2 ();
  vga_tile_scan_if ifSm ();

  vga_tile_scan #(.DRAW_LATENCY(0)) dutL0 (.i_clk(clk), .i_rst_n(rstN), .vga(ifL0));
  vga_tile_scan #(.DRAW_LATENCY(1)) dutL1 (.i_clk(clk), .i_rst_n(rstN), .vga(ifL1));
  vga_tile_scan #(.DRAW_LATENCY(2)) dutL2 (.i_clk(clk), .i_rst_n(rstN), .vga(ifL2));

  // Small raster: 80 x 54 total, 64 x 48 visible, so one frame is 4320 cycles.
  vga_tile_scan #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .TILE_SHIFT(4), .DRAW_LATENCY(1)
  ) dutSm (.i_clk(clk), .i_rst_n(rstSmallN), .vga(ifSm));

  function automatic longint px(input int h, input int v);
    return longint'(v) * 800 + h;
  endfunction

  // Advance to the negedge where the default DUTs present linear pixel 'target'.
  task automatic applyStimulus(input longint target);
    while (curPix < target) begin
      @(negedge clk);
      curPix++;
    end
  endtask

  task automatic test_reset();
    rstN      = 1'b0;
    rstSmallN = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if ({ifL1.o_row, ifL1.o_col, ifL1.o_active, ifL1.o_frame_start, ifL1.o_frame_tick} !== 15'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got row=%0d col=%0d act=%0b fs=%0b ft=%0b exp all 0",
               ifL1.o_row, ifL1.o_col, ifL1.o_active, ifL1.o_frame_start, ifL1.o_frame_tick);
    end
    total++;
    if ({ifL0.o_hsync_d, ifL0.o_vsync_d, ifL0.o_active_d,
         ifL1.o_hsync_d, ifL1.o_vsync_d, ifL1.o_active_d,
         ifL2.o_hsync_d, ifL2.o_vsync_d, ifL2.o_active_d,
         ifSm.o_hsync_d, ifSm.o_vsync_d, ifSm.o_active_d} !== 12'b110_110_110_110) begin
      bad++;
      $display("[TB] FAIL reset_delayed got L0=%b%b%b L1=%b%b%b L2=%b%b%b exp 110 each",
               ifL0.o_hsync_d, ifL0.o_vsync_d, ifL0.o_active_d,
               ifL1.o_hsync_d, ifL1.o_vsync_d, ifL1.o_active_d,
               ifL2.o_hsync_d, ifL2.o_vsync_d, ifL2.o_active_d);
    end
  endtask

  // Release at a negedge; the next edge must present pixel (0,0).
  task automatic test_first_pixel(input string tag);
    logic [2:0] expAd [3];
    expAd  = '{3'b001, 3'b011, 3'b111};
    rstN   = 1'b1;
    curPix = -1;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(p);
      total++;
      if ({ifL1.o_active, ifL1.o_row, ifL1.o_col, ifL1.o_frame_start} !== {1'b1, 6'd0, 6'd0, (p == 0)}) begin
        bad++;
        $display("[TB] FAIL %s_pix%0d got act=%0b row=%0d col=%0d fs=%0b exp act=1 row=0 col=0 fs=%0b",
                 tag, p, ifL1.o_active, ifL1.o_row, ifL1.o_col, ifL1.o_frame_start, (p == 0));
      end
      total++;
      if ({ifL2.o_active_d, ifL1.o_active_d, ifL0.o_active_d,
           ifL2.o_hsync_d, ifL1.o_hsync_d, ifL0.o_hsync_d} !== {expAd[p], 3'b111}) begin
        bad++;
        $display("[TB] FAIL %s_latency%0d got act_d(L2L1L0)=%b%b%b hs_d=%b%b%b exp act_d=%b hs_d=111",
                 tag, p, ifL2.o_active_d, ifL1.o_active_d, ifL0.o_active_d,
                 ifL2.o_hsync_d, ifL1.o_hsync_d, ifL0.o_hsync_d, expAd[p]);
      end
    end
  endtask

  task automatic test_tile_cols();
    int tab [4][5] = '{'{15, 0, 1, 0, 0}, '{16, 0, 1, 0, 1},
                       '{639, 0, 1, 0, 39}, '{640, 0, 0, 0, 0}};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(px(tab[i][0], tab[i][1]));
      total++;
      if ({ifL1.o_active, ifL1.o_row, ifL1.o_col} !== {tab[i][2][0], 6'(tab[i][3]), 6'(tab[i][4])}) begin
        bad++;
        $display("[TB] FAIL col(%0d,%0d) got act=%0b row=%0d col=%0d exp act=%0d row=%0d col=%0d",
                 tab[i][0], tab[i][1], ifL1.o_active, ifL1.o_row, ifL1.o_col,
                 tab[i][2], tab[i][3], tab[i][4]);
      end
    end
  endtask

  task automatic test_hsync();
    int         cnt    [3];
    longint     first  [3];
    longint     second [3];
    logic [2:0] hs;
    cnt    = '{0, 0, 0};
    first  = '{-1, -1, -1};
    second = '{-1, -1, -1};
    for (longint p = 641; p < 1600; p++) begin
      applyStimulus(p);
      hs = {ifL2.o_hsync_d, ifL1.o_hsync_d, ifL0.o_hsync_d};
      for (int k = 0; k < 3; k++) begin
        if (hs[k] == 1'b0) begin
          if (p < 800) begin
            cnt[k]++;
            if (first[k] < 0) first[k] = p;
          end else if (second[k] < 0) begin
            second[k] = p;
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cnt[k] !== 96) begin
        bad++;
        $display("[TB] FAIL hsync_width_L%0d got=%0d exp=96", k, cnt[k]);
      end
      total++;
      if (first[k] !== longint'(656 + k)) begin
        bad++;
        $display("[TB] FAIL hsync_start_L%0d got=%0d exp=%0d", k, first[k], 656 + k);
      end
      total++;
      if (second[k] - first[k] !== 800) begin
        bad++;
        $display("[TB] FAIL hsync_period_L%0d got=%0d exp=800", k, second[k] - first[k]);
      end
    end
  endtask

  task automatic test_tile_rows();
    int tab [6][5] = '{'{0, 15, 1, 0, 0}, '{0, 16, 1, 1, 0}, '{100, 16, 1, 1, 6},
                       '{799, 16, 0, 0, 0}, '{0, 32, 1, 2, 0}, '{650, 32, 0, 0, 0}};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(px(tab[i][0], tab[i][1]));
      total++;
      if ({ifL1.o_active, ifL1.o_row, ifL1.o_col} !== {tab[i][2][0], 6'(tab[i][3]), 6'(tab[i][4])}) begin
        bad++;
        $display("[TB] FAIL row(%0d,%0d) got act=%0b row=%0d col=%0d exp act=%0d row=%0d col=%0d",
                 tab[i][0], tab[i][1], ifL1.o_active, ifL1.o_row, ifL1.o_col,
                 tab[i][2], tab[i][3], tab[i][4]);
      end
    end
  endtask

  // Full frame on the small raster: tick at 48*80, vsync on lines 50..51, period 4320.
  task automatic test_frame();
    int     fsCnt = 0, ftCnt = 0, vsCnt = 0;
    longint fsLast = -1, ftAt = -1, vsFirst = -1;
    rstSmallN = 1'b1;
    smallBase = curPix + 1;
    for (longint s = 0; s <= 4320; s++) begin
      applyStimulus(smallBase + s);
      if (ifSm.o_frame_start) begin fsCnt++; fsLast = s; end
      if (ifSm.o_frame_tick)  begin ftCnt++; ftAt = s; end
      if (!ifSm.o_vsync_d) begin
        vsCnt++;
        if (vsFirst < 0) vsFirst = s;
      end
      if (s == 3823 || s == 3824 || s == 4320) begin
        total++;
        if ({ifSm.o_active, ifSm.o_row, ifSm.o_col} !==
            ((s == 3823) ? {1'b1, 6'd2, 6'd3} : (s == 3824) ? 13'd0 : {1'b1, 12'd0})) begin
          bad++;
          $display("[TB] FAIL small_pix%0d got act=%0b row=%0d col=%0d", s,
                   ifSm.o_active, ifSm.o_row, ifSm.o_col);
        end
      end
    end
    total++;
    if (fsCnt !== 2 || fsLast !== 4320) begin
      bad++;
      $display("[TB] FAIL frame_start got count=%0d last=%0d exp count=2 last=4320", fsCnt, fsLast);
    end
    total++;
    if (ftCnt !== 1 || ftAt !== 3840) begin
      bad++;
      $display("[TB] FAIL frame_tick got count=%0d at=%0d exp count=1 at=3840", ftCnt, ftAt);
    end
    total++;
    if (vsCnt !== 160 || vsFirst !== 4001) begin
      bad++;
      $display("[TB] FAIL vsync got width=%0d first=%0d exp width=160 first=4001", vsCnt, vsFirst);
    end
  endtask

  task automatic test_mid_reset();
    applyStimulus(px(300, 60));
    total++;
    if ({ifL1.o_active, ifL1.o_row, ifL1.o_col, ifL2.o_active_d, ifL1.o_active_d, ifL0.o_active_d}
        !== {1'b1, 6'd3, 6'd18, 3'b111}) begin
      bad++;
      $display("[TB] FAIL pre_reset got act=%0b row=%0d col=%0d act_d=%b%b%b exp act=1 row=3 col=18 act_d=111",
               ifL1.o_active, ifL1.o_row, ifL1.o_col, ifL2.o_active_d, ifL1.o_active_d, ifL0.o_active_d);
    end
    rstN = 1'b0;
    #1;
    total++;
    if ({ifL1.o_row, ifL1.o_col, ifL1.o_active, ifL0.o_active,
         ifL2.o_hsync_d, ifL2.o_vsync_d, ifL2.o_active_d,
         ifL1.o_hsync_d, ifL1.o_vsync_d, ifL1.o_active_d,
         ifL0.o_hsync_d, ifL0.o_vsync_d, ifL0.o_active_d} !== {14'd0, 9'b110_110_110}) begin
      bad++;
      $display("[TB] FAIL async_reset got row=%0d col=%0d act=%0b act_d=%b%b%b exp row=0 col=0 act=0 act_d=000",
               ifL1.o_row, ifL1.o_col, ifL1.o_active, ifL2.o_active_d, ifL1.o_active_d, ifL0.o_active_d);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({ifL2.o_hsync_d, ifL2.o_vsync_d, ifL2.o_active_d, ifL1.o_frame_start} !== 4'b1100) begin
      bad++;
      $display("[TB] FAIL held_reset got L2=%b%b%b fs=%b exp L2=110 fs=0",
               ifL2.o_hsync_d, ifL2.o_vsync_d, ifL2.o_active_d, ifL1.o_frame_start);
    end
  endtask

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_first_pixel("start");
    test_tile_cols();
    test_hsync();
    test_tile_rows();
    test_frame();
    test_mid_reset();
    test_first_pixel("restart");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_tile_scan.md
Name: vga_tile_scan

Overview:
- Upstream neighbour of the pong game logic. Generates 640x480@60 VGA timing from the 25 MHz board clock.
- Produces the tile coordinates (o_row/o_col) that the game consumes. Coordinates are pixel >> TILE_SHIFT, giving 40x30 tiles at the defaults.
- Also produces sync/active signals delayed to line up with the game's registered o_draw, plus a once-per-frame tick for game-state updates.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- TILE_SHIFT, 4, log2 of tile size in pixels
- DRAW_LATENCY, 1, cycles by which the *_d outputs lag o_row/o_col; range 0..4

Ports:
- i_clk  in  1  pixel clock, 25 MHz
- i_rst_n  in  1  asynchronous reset, active low
- o_row  out  6  tile row of the current pixel
- o_col  out  6  tile column of the current pixel
- o_active  out  1  current pixel is in the visible area
- o_frame_start  out  1  one-cycle pulse at pixel (0,0)
- o_frame_tick  out  1  one-cycle pulse at pixel (0,V_ACTIVE), i.e. start of vertical blanking; game-update strobe
- o_hsync_d  out  1  hsync, active low, delayed DRAW_LATENCY cycles
- o_vsync_d  out  1  vsync, active low, delayed DRAW_LATENCY cycles
- o_active_d  out  1  o_active delayed DRAW_LATENCY cycles; gates the colour outputs with o_draw

Behaviour:
- Reset is one clock domain, asynchronous assert, active low.
- Counters:
  - h_cnt and v_cnt are 10 bits.
  - H_TOTAL = 800 (sum of the H parameters); V_TOTAL = 525 (sum of the V parameters).
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0. On that wrap, v_cnt increments; v_cnt wraps from V_TOTAL-1 to 0.
- Output registration:
  - All outputs are registered decodes of the current counter value, so an output on edge k reflects the counter value before edge k.
  - The first edge after reset release presents pixel (0,0).
- Decode rules:
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - o_col = h >> TILE_SHIFT and o_row = v >> TILE_SHIFT while active; both are forced to 0 in blanking.
  - hsync is low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, which is h = 656..751 at the defaults.
  - vsync is low for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, which is lines 490..491 at the defaults.
  - o_frame_start is 1 only for (h,v) = (0,0). o_frame_tick is 1 only for (0,V_ACTIVE).
- Delay line:
  - hsync, vsync and active pass through a DRAW_LATENCY-deep shift register.
  - DRAW_LATENCY = 0 gives a combinational pass of the registered values.
- Reset values:
  - Counters = 0.
  - o_row = 0, o_col = 0, o_active = 0, o_frame_start = 0, o_frame_tick = 0.
  - All delay stages hold their inactive values: hsync 1, vsync 1, active 0. So o_hsync_d = 1, o_vsync_d = 1, o_active_d = 0.
- Reset mid-frame: everything returns to the reset values immediately. The scan restarts at (0,0) on the first edge after release. The delay line carries no stale active data.
- Widths:
  - H_ACTIVE >> TILE_SHIFT and V_ACTIVE >> TILE_SHIFT must each be <= 64. Elaboration is checked with a generate-time error.
  - H_TOTAL and V_TOTAL must each be <= 1024.

Decomposition:
- Shared package, pong_pkg, holds:
  - the VGA 640x480 timing constants;
  - TILE_SHIFT;
  - GAME_WIDTH = 40 and GAME_HEIGHT = 30, derived from the timing constants;
  - the coordinate width (6).
  Game modules and this block both take their values from it.
- One sub-module, sync_delay, is natural: a parameterised N-deep, W-wide shift register with an async active-low reset to a per-bit reset value. It is used for {hsync, vsync, active}.

Test Plan:
- Reset: hold i_rst_n = 0 for 5 cycles -> o_hsync_d = 1, o_vsync_d = 1, o_active_d = 0, o_row = 0, o_col = 0, both pulses = 0.
- First pixel: release reset -> on the first edge o_active = 1, o_row = 0, o_col = 0, o_frame_start = 1 for exactly one cycle. o_active_d rises DRAW_LATENCY cycles later.
- Tile boundaries on line 0:
  - pixels 15 and 16 -> o_col 0 then 1;
  - pixel 639 -> o_col 39, o_active 1;
  - pixel 640 -> o_active 0, o_col 0.
  - Lines 15/16 -> o_row 0/1; line 479 -> o_row 29.
- Horizontal sync: o_hsync_d low for exactly 96 cycles, starting 656 + DRAW_LATENCY cycles after line start; line period 800 cycles.
- Frame timing:
  - o_frame_tick pulses once, 480*800 cycles after o_frame_start.
  - o_vsync_d low for 1600 cycles starting at line 490.
  - Next o_frame_start arrives 420000 cycles after the previous one.
- Mid-frame reset and latency:
  - Assert i_rst_n = 0 at pixel (300,200) -> outputs at reset values asynchronously (before the next edge); after release the scan restarts at (0,0).
  - Repeat with DRAW_LATENCY = 2 and 0 -> *_d outputs shifted by 2 and 0 cycles respectively.
